alu_txn_ctrl: RTL and testbench

- Sequential initiator for the combinational 8-bit safe ALU (ports a, b, opcode, result, zero, carry, overflow).
- Accepts operation commands over a valid/ready channel and drives registered operands into the ALU.
- Waits a programmable settle time, captures the result and flags, and returns them over a valid/ready response channel.
- Keeps saturating statistics counters.
- Replaces ad-hoc direct ALU driving in the datapath.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/sat_counter.sv | 35 +++
 rtl/alu_txn_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_txn_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU transaction controller: opcodes, flag bit
// positions and the controller state encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_DRIVE   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_txn_ctrl.sv
// Valid/ready initiator for the combinational safe ALU: registers a command onto
// the ALU inputs, waits SETTLE cycles, captures result/flags and returns them.
module alu_txn_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_a_i,
    input  logic [DATA_W-1:0] cmd_b_i,
    input  logic [1:0]        cmd_op_i,
    input  logic [TAG_W-1:0]  cmd_tag_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [1:0]        alu_opcode_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_carry_i,
    input  logic              alu_overflow_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic [2:0]        rsp_flags_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  op_count_o,
    output logic [CNT_W-1:0]  ovf_count_o,
    output logic              busy_o
);

    // Settle counter starts at SETTLE-1 so DRIVE lasts exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [2:0]          rsp_flags_q, rsp_flags_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                op_inc;
    logic                ovf_inc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_tag_d    = rsp_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    alu_a_d  = cmd_a_i;
                    alu_b_d  = cmd_b_i;
                    alu_op_d = cmd_op_i;
                    tag_d    = cmd_tag_i;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                rsp_result_d        = alu_result_i;
                rsp_flags_d[FLG_Z]  = alu_zero_i;
                rsp_flags_d[FLG_C]  = alu_carry_i;
                rsp_flags_d[FLG_V]  = alu_overflow_i;
                rsp_tag_d           = tag_q;
                state_d             = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_op_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign rsp_tag_o    = rsp_tag_q;

    assign op_inc  = rsp_valid_o && rsp_ready_i;
    assign ovf_inc = op_inc && rsp_flags_q[FLG_V];

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_op_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (op_inc),
        .clr_i   (clr_stats_i),
        .count_o (op_count_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (ovf_inc),
        .clr_i   (clr_stats_i),
        .count_o (ovf_count_o)
    );

endmodule

// File: tb/tb_alu_txn_ctrl.sv
// Bench for alu_txn_ctrl: two instances (SETTLE=1/CNT_W=16 and SETTLE=4/CNT_W=2),
// each wired to a behavioural safe ALU; directed table, sequences and random ops.
module tb_alu_txn_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid[2], cmd_ready[2], rsp_valid[2], rsp_ready[2];
    logic       clr_stats[2], busy[2];
    logic [7:0] cmd_a[2], cmd_b[2], alu_a[2], alu_b[2], alu_r[2], rsp_result[2];
    logic [1:0] cmd_op[2], alu_op[2];
    logic [3:0] cmd_tag[2], rsp_tag[2];
    logic       alu_z[2], alu_c[2], alu_v[2];
    logic [2:0] rsp_flags[2];
    logic [15:0] op_cnt0, ovf_cnt0, op_cnt[2], ovf_cnt[2];
    logic [1:0]  op_cnt1, ovf_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops[2];
    int exp_ovf[2];
    int cnt_max[2] = '{65535, 3};
    int lat_exp[2] = '{2, 5};

    // Stand-in for the safe ALU; SUB reports borrow on the carry flag.
    function automatic logic [10:0] safe_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND:  r = a & b;
            default: r = a | b;
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            {alu_v[i], alu_c[i], alu_z[i], alu_r[i]} = safe_alu(alu_a[i], alu_b[i], alu_op[i]);
        end
        op_cnt[0]  = op_cnt0;
        op_cnt[1]  = {14'b0, op_cnt1};
        ovf_cnt[0] = ovf_cnt0;
        ovf_cnt[1] = {14'b0, ovf_cnt1};
    end

    alu_txn_ctrl #(.DATA_W(8), .TAG_W(4), .SETTLE(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
        .cmd_a_i(cmd_a[0]), .cmd_b_i(cmd_b[0]), .cmd_op_i(cmd_op[0]), .cmd_tag_i(cmd_tag[0]),
        .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_opcode_o(alu_op[0]),
        .alu_result_i(alu_r[0]), .alu_zero_i(alu_z[0]), .alu_carry_i(alu_c[0]),
        .alu_overflow_i(alu_v[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_result_o(rsp_result[0]), .rsp_flags_o(rsp_flags[0]), .rsp_tag_o(rsp_tag[0]),
        .clr_stats_i(clr_stats[0]), .op_count_o(op_cnt0), .ovf_count_o(ovf_cnt0),
        .busy_o(busy[0])
    );

    alu_txn_ctrl #(.DATA_W(8), .TAG_W(4), .SETTLE(4), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
        .cmd_a_i(cmd_a[1]), .cmd_b_i(cmd_b[1]), .cmd_op_i(cmd_op[1]), .cmd_tag_i(cmd_tag[1]),
        .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_opcode_o(alu_op[1]),
        .alu_result_i(alu_r[1]), .alu_zero_i(alu_z[1]), .alu_carry_i(alu_c[1]),
        .alu_overflow_i(alu_v[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_result_o(rsp_result[1]), .rsp_flags_o(rsp_flags[1]), .rsp_tag_o(rsp_tag[1]),
        .clr_stats_i(clr_stats[1]), .op_count_o(op_cnt1), .ovf_count_o(ovf_cnt1),
        .busy_o(busy[1])
    );

    // Reference: plain integer arithmetic, returns {v, c, z, result}.
    function automatic logic [10:0] ref_op(input int a, input int b, input int op);
        int u, sa, sb, ss;
        logic [7:0] r;
        logic c, v;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        u = 0; ss = 0; c = 1'b0;
        case (op)
            0:       begin u = a + b; ss = sa + sb; c = (u > 255); end
            1:       begin u = a - b; ss = sa - sb; c = (a < b);   end
            2:       u = a & b;
            default: u = a | b;
        endcase
        r = u[7:0];
        v = (op < 2) && ((ss > 127) || (ss < -128));
        return {v, c, (r == 8'h00), r};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired waiting for DUT", name);
    endtask

    task automatic model_done(input int d, input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] op, input logic clr);
        logic [10:0] e;
        e = ref_op(int'(a), int'(b), int'(op));
        if (clr) begin
            exp_ops[d] = 0;
            exp_ovf[d] = 0;
        end else begin
            if (exp_ops[d] < cnt_max[d]) exp_ops[d]++;
            if (e[10] && exp_ovf[d] < cnt_max[d]) exp_ovf[d]++;
        end
    endtask

    task automatic check_reset(input int d);
        check("rst_cmd_ready", 32'(cmd_ready[d]), 1);
        check("rst_rsp_valid", 32'(rsp_valid[d]), 0);
        check("rst_busy", 32'(busy[d]), 0);
        check("rst_alu_a", 32'(alu_a[d]), 0);
        check("rst_alu_b", 32'(alu_b[d]), 0);
        check("rst_alu_op", 32'(alu_op[d]), 0);
        check("rst_rsp_result", 32'(rsp_result[d]), 0);
        check("rst_rsp_flags", 32'(rsp_flags[d]), 0);
        check("rst_rsp_tag", 32'(rsp_tag[d]), 0);
        check("rst_op_count", 32'(op_cnt[d]), 0);
        check("rst_ovf_count", 32'(ovf_cnt[d]), 0);
    endtask

    task automatic wait_accept(input int d, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            ok = cmd_ready[d];
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic wait_rsp(input int d, output int lat);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[d]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) fail_now("rsp_timeout");
    endtask

    // Full transaction; hold = cycles of rsp_ready=0 after rsp_valid appears,
    // clr = pulse clr_stats on the completing edge.
    task automatic do_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [3:0] tag, input int hold,
                          input logic clr, output int lat, output logic [7:0] res,
                          output logic [2:0] fl, output logic [3:0] tg);
        logic ok;
        res = '0; fl = '0; tg = '0; lat = -1;
        cmd_a[d] = a; cmd_b[d] = b; cmd_op[d] = op; cmd_tag[d] = tag;
        cmd_valid[d] = 1'b1;
        rsp_ready[d] = (hold == 0);
        wait_accept(d, ok);
        cmd_valid[d] = 1'b0;
        if (ok) wait_rsp(d, lat);
        res = rsp_result[d]; fl = rsp_flags[d]; tg = rsp_tag[d];
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready[d] = 1'b1;
        clr_stats[d] = clr;
        @(posedge clk); #1;
        clr_stats[d] = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid[d]), 0);
        model_done(d, a, b, op, clr);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [3:0] tag;
        logic [7:0] res;
        logic [2:0] fl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        logic ok, seen;
        logic [7:0] res;
        logic [2:0] fl;
        logic [3:0] tg;
        logic [10:0] e;
        logic [7:0] ra, rb;
        logic [1:0] rop;
        logic [3:0] rtag;

        vecs[0] = '{8'h0A, 8'h14, OP_ADD, 4'h3, 8'h1E, 3'b000};
        vecs[1] = '{8'h7F, 8'h81, OP_SUB, 4'h5, 8'hFE, 3'b110};
        vecs[2] = '{8'hAA, 8'hCC, OP_AND, 4'h2, 8'h88, 3'b000};
        vecs[3] = '{8'hFF, 8'h01, OP_ADD, 4'h9, 8'h00, 3'b011};
        vecs[4] = '{8'h7F, 8'h01, OP_ADD, 4'hA, 8'h80, 3'b100};
        vecs[5] = '{8'h05, 8'h05, OP_SUB, 4'hC, 8'h00, 3'b001};
        vecs[6] = '{8'h0F, 8'hF0, OP_OR,  4'hF, 8'hFF, 3'b000};
        vecs[7] = '{8'h00, 8'h01, OP_SUB, 4'h0, 8'hFF, 3'b010};

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0; clr_stats[d] = 1'b0;
            cmd_a[d] = '0; cmd_b[d] = '0; cmd_op[d] = '0; cmd_tag[d] = '0;
            exp_ops[d] = 0; exp_ovf[d] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table on the SETTLE=1 instance.
        for (int i = 0; i < 8; i++) begin
            do_txn(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 0, 1'b0, lat, res, fl, tg);
            check("vec_result", 32'(res), 32'(vecs[i].res));
            check("vec_flags", 32'(fl), 32'(vecs[i].fl));
            check("vec_tag", 32'(tg), 32'(vecs[i].tag));
            check("vec_latency", 32'(lat), 2);
            check("vec_op_count", 32'(op_cnt[0]), 32'(exp_ops[0]));
            check("vec_ovf_count", 32'(ovf_cnt[0]), 32'(exp_ovf[0]));
            check("vec_alu_a_hold", 32'(alu_a[0]), 32'(vecs[i].a));
            check("vec_alu_b_hold", 32'(alu_b[0]), 32'(vecs[i].b));
            check("vec_alu_op_hold", 32'(alu_op[0]), 32'(vecs[i].op));
        end

        // Backpressure with a second command held on the input.
        rsp_ready[0] = 1'b0;
        cmd_a[0] = 8'hAA; cmd_b[0] = 8'hCC; cmd_op[0] = OP_AND; cmd_tag[0] = 4'h7;
        cmd_valid[0] = 1'b1;
        wait_accept(0, ok);
        cmd_a[0] = 8'h0F; cmd_b[0] = 8'hF0; cmd_op[0] = OP_OR; cmd_tag[0] = 4'h8;
        wait_rsp(0, lat);
        check("bp_latency", 32'(lat), 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", 32'(rsp_result[0]), 32'h88);
            check("bp_tag", 32'(rsp_tag[0]), 7);
            check("bp_rsp_valid", 32'(rsp_valid[0]), 1);
            check("bp_cmd_ready", 32'(cmd_ready[0]), 0);
            check("bp_alu_a", 32'(alu_a[0]), 32'hAA);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 32'(cmd_ready[0]), 1);
        check("bp_rsp_drop", 32'(rsp_valid[0]), 0);
        check("bp_second_not_yet", 32'(alu_a[0]), 32'hAA);
        @(posedge clk); #1;
        check("bp_second_alu_a", 32'(alu_a[0]), 32'h0F);
        check("bp_second_alu_op", 32'(alu_op[0]), 32'(OP_OR));
        check("bp_second_busy", 32'(busy[0]), 1);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp_second_latency", 32'(lat), 2);
        check("bp_second_result", 32'(rsp_result[0]), 32'hFF);
        check("bp_second_tag", 32'(rsp_tag[0]), 8);
        @(posedge clk); #1;
        model_done(0, 8'hAA, 8'hCC, OP_AND, 1'b0);
        model_done(0, 8'h0F, 8'hF0, OP_OR, 1'b0);
        check("bp_op_count", 32'(op_cnt[0]), 32'(exp_ops[0]));

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rop = 2'($urandom_range(0, 3)); rtag = 4'($urandom);
            e = ref_op(int'(ra), int'(rb), int'(rop));
            do_txn(0, ra, rb, rop, rtag, int'($urandom_range(0, 3)), 1'b0, lat, res, fl, tg);
            check("rnd_result", 32'(res), 32'(e[7:0]));
            check("rnd_flags", 32'(fl), 32'(e[10:8]));
            check("rnd_tag", 32'(tg), 32'(rtag));
            check("rnd_latency", 32'(lat), 32'(lat_exp[0]));
            check("rnd_op_count", 32'(op_cnt[0]), 32'(exp_ops[0]));
            check("rnd_ovf_count", 32'(ovf_cnt[0]), 32'(exp_ovf[0]));
        end

        // Standalone clear.
        clr_stats[0] = 1'b1;
        @(posedge clk); #1;
        clr_stats[0] = 1'b0;
        check("clr_op_count", 32'(op_cnt[0]), 0);
        check("clr_ovf_count", 32'(ovf_cnt[0]), 0);
        exp_ops[0] = 0; exp_ovf[0] = 0;

        // Reset in the middle of DRIVE: no response afterwards.
        do_txn(0, 8'h7F, 8'h01, OP_ADD, 4'h3, 0, 1'b0, lat, res, fl, tg);
        cmd_a[0] = 8'hFF; cmd_b[0] = 8'hFF; cmd_op[0] = OP_AND; cmd_tag[0] = 4'h6;
        cmd_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        wait_accept(0, ok);
        check("mid_busy", 32'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        cmd_valid[0] = 1'b0;
        check_reset(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid[0];
        end
        check("mid_no_rsp", 32'(seen), 0);
        check("mid_idle", 32'(busy[0]), 0);
        exp_ops[0] = 0; exp_ovf[0] = 0;
        exp_ops[1] = 0; exp_ovf[1] = 0;

        // SETTLE=4 instance: zero flag and latency.
        do_txn(1, 8'h00, 8'h00, OP_OR, 4'h1, 0, 1'b0, lat, res, fl, tg);
        check("s4_latency", 32'(lat), 5);
        check("s4_result", 32'(res), 0);
        check("s4_flags", 32'(fl), 32'b001);
        check("s4_tag", 32'(tg), 1);
        check("s4_op_count", 32'(op_cnt[1]), 1);

        // Saturation with CNT_W=2.
        for (int i = 0; i < 4; i++) begin
            ra = (i == 1) ? 8'h7F : 8'($urandom_range(0, 63));
            rb = (i == 1) ? 8'h01 : 8'($urandom_range(0, 63));
            do_txn(1, ra, rb, OP_ADD, 4'(i), int'($urandom_range(0, 2)), 1'b0,
                   lat, res, fl, tg);
            check("sat_op_count", 32'(op_cnt[1]), 32'(exp_ops[1]));
            check("sat_ovf_count", 32'(ovf_cnt[1]), 32'(exp_ovf[1]));
        end
        check("sat_op_count_final", 32'(op_cnt[1]), 3);
        do_txn(1, 8'h7F, 8'h81, OP_SUB, 4'hE, 2, 1'b1, lat, res, fl, tg);
        check("sat_clr_result", 32'(res), 32'hFE);
        check("sat_clr_op_count", 32'(op_cnt[1]), 0);
        check("sat_clr_ovf_count", 32'(ovf_cnt[1]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
